// File: rtl/pu_or1k_execute_ctrl_skid.sv
// Execute->ctrl->wb pipeline register stage with valid/ready handshake and sticky late exceptions.
// Define PU_OR1K_EXEC_CTRL_SKID_EN to add a skid entry (registered ready, EMPTY/ONE/TWO FSM).

`ifndef OR1K_RESET_VECTOR
`define OR1K_RESET_VECTOR 5'h01
`endif

module pu_or1k_execute_ctrl_skid #(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC =
        {{(OPTION_OPERAND_WIDTH-13){1'b0}}, `OR1K_RESET_VECTOR, 8'd0},
    parameter int unsigned OPTION_RF_ADDR_WIDTH = 5,
    parameter int unsigned NUM_EXCEPT = 7,
    parameter int unsigned NUM_LATE_EXCEPT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_i,

    input  logic                            ex_valid_i,
    output logic                            ex_ready_o,
    input  logic                            ex_bubble_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ex_pc_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ex_result_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] ex_rfd_adr_i,
    input  logic                            ex_rf_wb_i,
    input  logic                            ex_longlat_i,
    input  logic [NUM_EXCEPT-1:0]           ex_except_i,

    input  logic [NUM_LATE_EXCEPT-1:0]      late_except_i,
    input  logic                            ctrl_ack_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_ack_data_i,
    input  logic                            padv_ctrl_i,

    output logic                            ctrl_valid_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] ctrl_pc_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] ctrl_result_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_o,
    output logic                            ctrl_rf_wb_o,
    output logic                            ctrl_longlat_o,
    output logic [NUM_EXCEPT-1:0]           ctrl_except_o,
    output logic [NUM_LATE_EXCEPT-1:0]      ctrl_late_except_o,
    output logic                            ctrl_except_any_o,

    output logic                            wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wb_result_o
);

    // ctrl entry
    logic                            ctrl_valid_q;
    logic [OPTION_OPERAND_WIDTH-1:0] ctrl_pc_q;
    logic [OPTION_OPERAND_WIDTH-1:0] ctrl_result_q;
    logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_q;
    logic                            ctrl_rf_wb_q;
    logic                            ctrl_longlat_q;
    logic [NUM_EXCEPT-1:0]           ctrl_except_q;
    logic [NUM_LATE_EXCEPT-1:0]      ctrl_late_except_q;

    // write-back
    logic                            wb_rf_wb_q;
    logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_q;
    logic [OPTION_OPERAND_WIDTH-1:0] wb_result_q;

    logic except_any;
    logic late_kill;
    logic retire;
    logic ex_ready;
    logic accept_entry;
    logic ctrl_load;
    logic ctrl_drop;

    logic [OPTION_OPERAND_WIDTH-1:0] nxt_pc;
    logic [OPTION_OPERAND_WIDTH-1:0] nxt_result;
    logic [OPTION_RF_ADDR_WIDTH-1:0] nxt_rfd_adr;
    logic                            nxt_rf_wb;
    logic                            nxt_longlat;
    logic [NUM_EXCEPT-1:0]           nxt_except;

    assign except_any = (|ctrl_except_q) | (|ctrl_late_except_q);
    // A late exception arriving this cycle outranks retirement of the same entry.
    assign late_kill  = ctrl_valid_q & (|late_except_i);
    assign retire     = ctrl_valid_q & padv_ctrl_i & (!ctrl_longlat_q | ctrl_ack_i) &
                        !except_any & !late_kill;

    // Bubbles complete the handshake but never occupy an entry; flush drops any offer.
    assign accept_entry = ex_valid_i & ex_ready & !ex_bubble_i & !flush_i;

`ifdef PU_OR1K_EXEC_CTRL_SKID_EN
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    logic [1:0] state_q, state_d;
    logic       ready_q;
    logic       ctrl_from_ex;
    logic       ctrl_from_skid;
    logic       skid_fill;

    logic [OPTION_OPERAND_WIDTH-1:0] skid_pc_q;
    logic [OPTION_OPERAND_WIDTH-1:0] skid_result_q;
    logic [OPTION_RF_ADDR_WIDTH-1:0] skid_rfd_adr_q;
    logic                            skid_rf_wb_q;
    logic                            skid_longlat_q;
    logic [NUM_EXCEPT-1:0]           skid_except_q;

    always_comb begin
        state_d        = state_q;
        ctrl_from_ex   = 1'b0;
        ctrl_from_skid = 1'b0;
        skid_fill      = 1'b0;
        ctrl_drop      = 1'b0;
        case (state_q)
            StEmpty: begin
                if (accept_entry) begin
                    state_d      = StOne;
                    ctrl_from_ex = 1'b1;
                end
            end
            StOne: begin
                if (accept_entry && !retire) begin
                    state_d   = StTwo;
                    skid_fill = 1'b1;
                end else if (accept_entry && retire) begin
                    ctrl_from_ex = 1'b1;
                end else if (retire) begin
                    state_d   = StEmpty;
                    ctrl_drop = 1'b1;
                end
            end
            StTwo: begin
                if (retire) begin
                    state_d        = StOne;
                    ctrl_from_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            ready_q <= 1'b1;
        end else if (flush_i) begin
            state_q <= StEmpty;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != StTwo);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_pc_q      <= '0;
            skid_result_q  <= '0;
            skid_rfd_adr_q <= '0;
            skid_rf_wb_q   <= 1'b0;
            skid_longlat_q <= 1'b0;
            skid_except_q  <= '0;
        end else if (flush_i) begin
            skid_rf_wb_q   <= 1'b0;
            skid_longlat_q <= 1'b0;
            skid_except_q  <= '0;
        end else if (skid_fill) begin
            skid_pc_q      <= ex_pc_i;
            skid_result_q  <= ex_result_i;
            skid_rfd_adr_q <= ex_rfd_adr_i;
            skid_rf_wb_q   <= ex_rf_wb_i;
            skid_longlat_q <= ex_longlat_i;
            skid_except_q  <= ex_except_i;
        end
    end

    assign ex_ready    = ready_q;
    assign ctrl_load   = ctrl_from_ex | ctrl_from_skid;
    assign nxt_pc      = ctrl_from_skid ? skid_pc_q      : ex_pc_i;
    assign nxt_result  = ctrl_from_skid ? skid_result_q  : ex_result_i;
    assign nxt_rfd_adr = ctrl_from_skid ? skid_rfd_adr_q : ex_rfd_adr_i;
    assign nxt_rf_wb   = ctrl_from_skid ? skid_rf_wb_q   : ex_rf_wb_i;
    assign nxt_longlat = ctrl_from_skid ? skid_longlat_q : ex_longlat_i;
    assign nxt_except  = ctrl_from_skid ? skid_except_q  : ex_except_i;
`else
    // Single entry: a retiring entry frees ctrl in the same cycle.
    assign ex_ready    = !ctrl_valid_q | retire;
    assign ctrl_load   = accept_entry;
    assign ctrl_drop   = retire & !accept_entry;
    assign nxt_pc      = ex_pc_i;
    assign nxt_result  = ex_result_i;
    assign nxt_rfd_adr = ex_rfd_adr_i;
    assign nxt_rf_wb   = ex_rf_wb_i;
    assign nxt_longlat = ex_longlat_i;
    assign nxt_except  = ex_except_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_valid_q       <= 1'b0;
            ctrl_pc_q          <= OPTION_RESET_PC;
            ctrl_result_q      <= '0;
            ctrl_rfd_adr_q     <= '0;
            ctrl_rf_wb_q       <= 1'b0;
            ctrl_longlat_q     <= 1'b0;
            ctrl_except_q      <= '0;
            ctrl_late_except_q <= '0;
        end else if (flush_i) begin
            ctrl_valid_q       <= 1'b0;
            ctrl_rf_wb_q       <= 1'b0;
            ctrl_longlat_q     <= 1'b0;
            ctrl_except_q      <= '0;
            ctrl_late_except_q <= '0;
        end else if (ctrl_load) begin
            ctrl_valid_q       <= 1'b1;
            ctrl_pc_q          <= nxt_pc;
            ctrl_result_q      <= nxt_result;
            ctrl_rfd_adr_q     <= nxt_rfd_adr;
            ctrl_rf_wb_q       <= nxt_rf_wb;
            ctrl_longlat_q     <= nxt_longlat;
            ctrl_except_q      <= nxt_except;
            ctrl_late_except_q <= '0;
        end else begin
            if (ctrl_drop) begin
                ctrl_valid_q <= 1'b0;
            end
            if (late_kill) begin
                ctrl_late_except_q <= ctrl_late_except_q | late_except_i;
                ctrl_rf_wb_q       <= 1'b0;
                ctrl_longlat_q     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_rf_wb_q   <= 1'b0;
            wb_rfd_adr_q <= '0;
            wb_result_q  <= '0;
        end else if (flush_i) begin
            wb_rf_wb_q <= 1'b0;
        end else begin
            wb_rf_wb_q <= retire & ctrl_rf_wb_q;
            if (retire && ctrl_rf_wb_q) begin
                wb_rfd_adr_q <= ctrl_rfd_adr_q;
                wb_result_q  <= ctrl_longlat_q ? ctrl_ack_data_i : ctrl_result_q;
            end
        end
    end

    assign ex_ready_o         = ex_ready;
    assign ctrl_valid_o       = ctrl_valid_q;
    assign ctrl_pc_o          = ctrl_pc_q;
    assign ctrl_result_o      = ctrl_result_q;
    assign ctrl_rfd_adr_o     = ctrl_rfd_adr_q;
    assign ctrl_rf_wb_o       = ctrl_rf_wb_q;
    assign ctrl_longlat_o     = ctrl_longlat_q;
    assign ctrl_except_o      = ctrl_except_q;
    assign ctrl_late_except_o = ctrl_late_except_q;
    assign ctrl_except_any_o  = except_any;
    assign wb_rf_wb_o         = wb_rf_wb_q;
    assign wb_rfd_adr_o       = wb_rfd_adr_q;
    assign wb_result_o        = wb_result_q;

endmodule

// File: tb/tb_pu_or1k_execute_ctrl_skid.sv
// Directed bench for pu_or1k_execute_ctrl_skid; RF writes are checked against a scoreboard queue.
// Follows PU_OR1K_EXEC_CTRL_SKID_EN to pick the matching ready/stall expectations.

module tb_pu_or1k_execute_ctrl_skid;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic        ex_bubble_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_result_i;
    logic [4:0]  ex_rfd_adr_i;
    logic        ex_rf_wb_i;
    logic        ex_longlat_i;
    logic [6:0]  ex_except_i;
    logic [3:0]  late_except_i;
    logic        ctrl_ack_i;
    logic [31:0] ctrl_ack_data_i;
    logic        padv_ctrl_i;
    logic        ctrl_valid_o;
    logic [31:0] ctrl_pc_o;
    logic [31:0] ctrl_result_o;
    logic [4:0]  ctrl_rfd_adr_o;
    logic        ctrl_rf_wb_o;
    logic        ctrl_longlat_o;
    logic [6:0]  ctrl_except_o;
    logic [3:0]  ctrl_late_except_o;
    logic        ctrl_except_any_o;
    logic        wb_rf_wb_o;
    logic [4:0]  wb_rfd_adr_o;
    logic [31:0] wb_result_o;

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] res;
    } wb_t;

    wb_t exp_q[$];
    wb_t exp_e;
    int  checks = 0;
    int  errors = 0;

    pu_or1k_execute_ctrl_skid dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .ex_valid_i         (ex_valid_i),
        .ex_ready_o         (ex_ready_o),
        .ex_bubble_i        (ex_bubble_i),
        .ex_pc_i            (ex_pc_i),
        .ex_result_i        (ex_result_i),
        .ex_rfd_adr_i       (ex_rfd_adr_i),
        .ex_rf_wb_i         (ex_rf_wb_i),
        .ex_longlat_i       (ex_longlat_i),
        .ex_except_i        (ex_except_i),
        .late_except_i      (late_except_i),
        .ctrl_ack_i         (ctrl_ack_i),
        .ctrl_ack_data_i    (ctrl_ack_data_i),
        .padv_ctrl_i        (padv_ctrl_i),
        .ctrl_valid_o       (ctrl_valid_o),
        .ctrl_pc_o          (ctrl_pc_o),
        .ctrl_result_o      (ctrl_result_o),
        .ctrl_rfd_adr_o     (ctrl_rfd_adr_o),
        .ctrl_rf_wb_o       (ctrl_rf_wb_o),
        .ctrl_longlat_o     (ctrl_longlat_o),
        .ctrl_except_o      (ctrl_except_o),
        .ctrl_late_except_o (ctrl_late_except_o),
        .ctrl_except_any_o  (ctrl_except_any_o),
        .wb_rf_wb_o         (wb_rf_wb_o),
        .wb_rfd_adr_o       (wb_rfd_adr_o),
        .wb_result_o        (wb_result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ex_valid_i      = 1'b0;
        ex_bubble_i     = 1'b0;
        ex_rf_wb_i      = 1'b0;
        ex_longlat_i    = 1'b0;
        ex_except_i     = '0;
        late_except_i   = '0;
        ctrl_ack_i      = 1'b0;
        flush_i         = 1'b0;
        padv_ctrl_i     = 1'b1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] adr,
                         input logic wb, input logic ll);
        ex_valid_i   = 1'b1;
        ex_bubble_i  = 1'b0;
        ex_pc_i      = pc;
        ex_result_i  = res;
        ex_rfd_adr_i = adr;
        ex_rf_wb_i   = wb;
        ex_longlat_i = ll;
        ex_except_i  = '0;
    endtask

    task automatic expect_wb(input logic [4:0] adr, input logic [31:0] res);
        wb_t e;
        e.adr = adr;
        e.res = res;
        exp_q.push_back(e);
    endtask

    // Every RF write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wb_rf_wb_o) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL wb_unexpected: observed adr %0d data %0h expected no write",
                       wb_rfd_adr_o, wb_result_o);
            end
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                checks++;
                assert ({wb_rfd_adr_o, wb_result_o} === {exp_e.adr, exp_e.res}) else begin
                    errors++;
                    $error("FAIL wb_data: observed adr %0d data %0h expected adr %0d data %0h",
                           wb_rfd_adr_o, wb_result_o, exp_e.adr, exp_e.res);
                end
            end
        end
    end

    initial begin
        ex_pc_i = '0; ex_result_i = '0; ex_rfd_adr_i = '0; ctrl_ack_data_i = '0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(ctrl_valid_o), 32'd0);
        chk("rst_pc", ctrl_pc_o, 32'h100);
        chk("rst_ready", 32'(ex_ready_o), 32'd1);
        chk("rst_wb", 32'(wb_rf_wb_o), 32'd0);
        chk("rst_except_any", 32'(ctrl_except_any_o), 32'd0);
        chk("rst_late", 32'(ctrl_late_except_o), 32'd0);
        chk("rst_wb_result", wb_result_o, 32'd0);
        rst = 1'b0;
        tick();

        // Back-to-back ALU ops; ack while not long-latency must not pick ack data.
        offer(32'h100, 32'h11, 5'd3, 1'b1, 1'b0);
        ctrl_ack_i = 1'b1;
        ctrl_ack_data_i = 32'hBAD0BAD0;
        expect_wb(5'd3, 32'h11);
        tick();
        chk("b2b_valid", 32'(ctrl_valid_o), 32'd1);
        chk("b2b_pc0", ctrl_pc_o, 32'h100);
        chk("b2b_adr0", 32'(ctrl_rfd_adr_o), 32'd3);
        offer(32'h104, 32'h22, 5'd4, 1'b1, 1'b0);
        expect_wb(5'd4, 32'h22);
        tick();
        chk("b2b_wb0", 32'(wb_rf_wb_o), 32'd1);
        chk("b2b_pc1", ctrl_pc_o, 32'h104);
        idle();
        tick();
        chk("b2b_wb1", 32'(wb_rf_wb_o), 32'd1);
        chk("b2b_wbadr1", 32'(wb_rfd_adr_o), 32'd4);
        chk("b2b_empty", 32'(ctrl_valid_o), 32'd0);
        chk("b2b_pc_hold", ctrl_pc_o, 32'h104);
        tick();
        chk("b2b_wb_done", 32'(wb_rf_wb_o), 32'd0);

        // Load held until acked, with a younger ALU op queued behind it.
        offer(32'h200, 32'h55, 5'd7, 1'b1, 1'b1);
        expect_wb(5'd7, 32'hDEADBEEF);
        tick();
        chk("ld_longlat", 32'(ctrl_longlat_o), 32'd1);
        chk("ld_pc", ctrl_pc_o, 32'h200);
        offer(32'h204, 32'h66, 5'd8, 1'b1, 1'b0);
        expect_wb(5'd8, 32'h66);
`ifdef PU_OR1K_EXEC_CTRL_SKID_EN
        tick();
        ex_valid_i = 1'b0;
        chk("ld_two_ready", 32'(ex_ready_o), 32'd0);
        chk("ld_two_pc", ctrl_pc_o, 32'h200);
        padv_ctrl_i = 1'b0; ctrl_ack_i = 1'b1; ctrl_ack_data_i = 32'h12345678;
        tick();
        padv_ctrl_i = 1'b1; ctrl_ack_i = 1'b0;
        tick();
        chk("ld_hold_valid", 32'(ctrl_valid_o), 32'd1);
        chk("ld_hold_ready", 32'(ex_ready_o), 32'd0);
        chk("ld_hold_pc", ctrl_pc_o, 32'h200);
        chk("ld_hold_wb", 32'(wb_rf_wb_o), 32'd0);
        ctrl_ack_i = 1'b1; ctrl_ack_data_i = 32'hDEADBEEF;
        tick();
        chk("ld_wb_data", wb_result_o, 32'hDEADBEEF);
        chk("ld_skid_pc", ctrl_pc_o, 32'h204);
        chk("ld_ready_back", 32'(ex_ready_o), 32'd1);
        ctrl_ack_i = 1'b0;
        tick();
`else
        #1;
        chk("ld_stall_ready", 32'(ex_ready_o), 32'd0);
        padv_ctrl_i = 1'b0; ctrl_ack_i = 1'b1; ctrl_ack_data_i = 32'h12345678;
        #1;
        chk("ld_nopadv_ready", 32'(ex_ready_o), 32'd0);
        tick();
        padv_ctrl_i = 1'b1; ctrl_ack_i = 1'b0;
        tick();
        tick();
        chk("ld_hold_valid", 32'(ctrl_valid_o), 32'd1);
        chk("ld_hold_ready", 32'(ex_ready_o), 32'd0);
        chk("ld_hold_pc", ctrl_pc_o, 32'h200);
        chk("ld_hold_wb", 32'(wb_rf_wb_o), 32'd0);
        ctrl_ack_i = 1'b1; ctrl_ack_data_i = 32'hDEADBEEF;
        #1;
        chk("ld_ack_ready", 32'(ex_ready_o), 32'd1);
        tick();
        chk("ld_wb_data", wb_result_o, 32'hDEADBEEF);
        chk("ld_next_pc", ctrl_pc_o, 32'h204);
        idle();
        tick();
`endif
        chk("ld_alu_adr", 32'(wb_rfd_adr_o), 32'd8);
        chk("ld_alu_empty", 32'(ctrl_valid_o), 32'd0);
        idle();
        tick();

        // Late exception kills the load's write-back and sticks until flush.
        offer(32'h240, 32'h99, 5'd9, 1'b1, 1'b1);
        tick();
        idle();
        late_except_i = 4'b0001;
        tick();
        late_except_i = 4'b0000;
        chk("late_rf_wb", 32'(ctrl_rf_wb_o), 32'd0);
        chk("late_longlat", 32'(ctrl_longlat_o), 32'd0);
        chk("late_any", 32'(ctrl_except_any_o), 32'd1);
        chk("late_flags", 32'(ctrl_late_except_o), 32'h1);
        ctrl_ack_i = 1'b1;
        tick();
        tick();
        chk("late_stuck_valid", 32'(ctrl_valid_o), 32'd1);
`ifdef PU_OR1K_EXEC_CTRL_SKID_EN
        chk("late_ready", 32'(ex_ready_o), 32'd1);
`else
        chk("late_ready", 32'(ex_ready_o), 32'd0);
`endif
        late_except_i = 4'b0100;
        tick();
        late_except_i = 4'b0000;
        chk("late_sticky", 32'(ctrl_late_except_o), 32'h5);
        flush_i = 1'b1; ctrl_ack_i = 1'b0;
        tick();
        flush_i = 1'b0;
        chk("late_flush_valid", 32'(ctrl_valid_o), 32'd0);
        chk("late_flush_flags", 32'(ctrl_late_except_o), 32'd0);
        chk("late_flush_any", 32'(ctrl_except_any_o), 32'd0);
        chk("late_flush_pc", ctrl_pc_o, 32'h240);
        chk("late_flush_ready", 32'(ex_ready_o), 32'd1);

        // Early exception entry never retires.
        offer(32'h280, 32'hAA, 5'd10, 1'b1, 1'b0);
        ex_except_i = 7'b0000100;
        tick();
        idle();
        chk("early_flags", 32'(ctrl_except_o), 32'h4);
        chk("early_any", 32'(ctrl_except_any_o), 32'd1);
        tick();
        chk("early_stuck", 32'(ctrl_valid_o), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("early_flush", 32'(ctrl_except_o), 32'd0);

        // Bubbles are accepted and dropped.
        offer(32'h300, 32'h77, 5'd11, 1'b0, 1'b0);
        tick();
        chk("bub_pc0", ctrl_pc_o, 32'h300);
        offer(32'h304, 32'h78, 5'd12, 1'b1, 1'b0);
        ex_bubble_i = 1'b1;
        tick();
        chk("bub_pc_hold", ctrl_pc_o, 32'h300);
        chk("bub_drop_valid", 32'(ctrl_valid_o), 32'd0);
        tick();
        chk("bub_pc_hold2", ctrl_pc_o, 32'h300);
        chk("bub_empty", 32'(ctrl_valid_o), 32'd0);
        chk("bub_no_wb", 32'(wb_rf_wb_o), 32'd0);
        offer(32'h308, 32'h88, 5'd13, 1'b1, 1'b0);
        padv_ctrl_i = 1'b0;
        expect_wb(5'd13, 32'h88);
        tick();
        chk("bub_pc1", ctrl_pc_o, 32'h308);
        ex_bubble_i = 1'b1;
        ex_pc_i = 32'h30C;
        tick();
        chk("bub_stall_pc", ctrl_pc_o, 32'h308);
        chk("bub_stall_valid", 32'(ctrl_valid_o), 32'd1);
`ifdef PU_OR1K_EXEC_CTRL_SKID_EN
        chk("bub_no_two", 32'(ex_ready_o), 32'd1);
`endif
        idle();
        tick();
        chk("bub_retire_adr", 32'(wb_rfd_adr_o), 32'd13);
        chk("bub_retire_empty", 32'(ctrl_valid_o), 32'd0);

        // Flush while full, with a new offer present.
        offer(32'h400, 32'hC0, 5'd14, 1'b1, 1'b1);
        tick();
        offer(32'h404, 32'hC4, 5'd15, 1'b1, 1'b0);
        tick();
        chk("fl_full_ready", 32'(ex_ready_o), 32'd0);
        flush_i = 1'b1;
        ex_pc_i = 32'h408;
        tick();
        flush_i = 1'b0;
        chk("fl_valid", 32'(ctrl_valid_o), 32'd0);
        chk("fl_ready", 32'(ex_ready_o), 32'd1);
        chk("fl_wb", 32'(wb_rf_wb_o), 32'd0);
        idle();
        tick();
        chk("fl_skid_gone", 32'(ctrl_valid_o), 32'd0);
        chk("fl_pc", ctrl_pc_o, 32'h400);
        offer(32'h40C, 32'hCC, 5'd16, 1'b1, 1'b0);
        flush_i = 1'b1;
        #1;
        chk("fl_empty_ready", 32'(ex_ready_o), 32'd1);
        tick();
        idle();
        chk("fl_drop_valid", 32'(ctrl_valid_o), 32'd0);
        chk("fl_drop_pc", ctrl_pc_o, 32'h400);

        // Asynchronous reset in the middle of a stall.
        offer(32'h500, 32'hD0, 5'd17, 1'b1, 1'b1);
        tick();
        offer(32'h504, 32'hD4, 5'd18, 1'b1, 1'b0);
        tick();
        chk("rs_stall_ready", 32'(ex_ready_o), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rs_valid", 32'(ctrl_valid_o), 32'd0);
        chk("rs_pc", ctrl_pc_o, 32'h100);
        chk("rs_ready", 32'(ex_ready_o), 32'd1);
        chk("rs_wb", 32'(wb_rf_wb_o), 32'd0);
        idle();
        tick();
        rst = 1'b0;
        tick();
        chk("rs_after", 32'(ctrl_valid_o), 32'd0);

        tick();
        chk("wb_pending", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
